// File: rtl/etc_accum_drain.sv
// Element-wise K-dimension reduction of 4x4 result tiles from etcEX, with a
// double-buffered drain that streams each finished tile out one row per cycle.
module etc_accum_drain #(
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               op,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [3:0][3:0][W-1:0]   in_tile,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_row,
  output logic                     out_last,
  output logic [3:0][W-1:0]        out_data,
  output logic                     busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MAX = 4'b0001;
  localparam logic [3:0] OP_MIN = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;

  function automatic logic [W-1:0] reduce_elem(input logic [3:0] sel,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    case (sel)
      OP_ADD:  return a + b;
      OP_MAX:  return (a > b) ? a : b;
      OP_MIN:  return (a < b) ? a : b;
      OP_OR:   return a | b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [3:0][3:0][W-1:0] reduce_tile(input logic [3:0] sel,
                                                          input logic [3:0][3:0][W-1:0] a,
                                                          input logic [3:0][3:0][W-1:0] b);
    logic [3:0][3:0][W-1:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = reduce_elem(sel, a[i][j], b[i][j]);
    return r;
  endfunction

  logic [3:0][3:0][W-1:0] acc;
  logic [3:0][3:0][W-1:0] drain;
  logic [3:0][3:0][W-1:0] red;
  logic [3:0]             op_q;
  logic                   pending;
  logic                   first;
  logic                   accept;
  logic                   drain_free;
  logic                   load_new;
  logic                   load_pend;

  assign in_ready   = !pending;
  assign accept     = in_valid && in_ready;
  // The drain buffer counts as free in the cycle its last row is taken.
  assign drain_free = !out_valid || (out_ready && (out_row == 2'd3));
  assign load_new   = accept && in_last && drain_free;
  assign load_pend  = pending && drain_free;

  always_comb begin
    red = first ? in_tile : reduce_tile(op_q, acc, in_tile);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      drain     <= '0;
      op_q      <= OP_ADD;
      pending   <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_row   <= 2'd0;
    end else begin
      // Accumulate stage: op is latched only on the first tile of a group.
      if (accept) begin
        if (first) op_q <= op;
        if (in_last) begin
          first <= 1'b1;
          if (!drain_free) begin
            acc     <= red;
            pending <= 1'b1;
          end
        end else begin
          acc   <= red;
          first <= 1'b0;
        end
      end
      // Drain stage: a reload takes priority over stepping the row index.
      if (load_new || load_pend) begin
        drain     <= load_new ? red : acc;
        out_valid <= 1'b1;
        out_row   <= 2'd0;
        if (load_pend) pending <= 1'b0;
      end else if (out_valid && out_ready) begin
        if (out_row == 2'd3) begin
          out_valid <= 1'b0;
          out_row   <= 2'd0;
        end else begin
          out_row <= out_row + 2'd1;
        end
      end
    end
  end

  assign out_data = drain[out_row];
  assign out_last = (out_row == 2'd3);
  assign busy     = !first || pending || out_valid;

endmodule

// File: tb/tb_etc_accum_drain.sv
// Randomised and directed bench for etc_accum_drain against a tile-level
// reduction model.
module tb_etc_accum_drain;

  localparam int W = 16;
  typedef logic [3:0][3:0][W-1:0] tile_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        op;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  tile_t             in_tile;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_row;
  logic              out_last;
  logic [3:0][W-1:0] out_data;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  etc_accum_drain #(.W(W)) dut (
    .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_tile(in_tile), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: element-wise fold over the group with the first tile's op.
  function automatic int elem_ref(int sel, int a, int b);
    case (sel)
      1:       return (a > b) ? a : b;
      2:       return (a < b) ? a : b;
      3:       return a | b;
      default: return (a + b) % 65536;
    endcase
  endfunction

  function automatic tile_t group_ref(int sel, tile_t t[4], int n);
    tile_t r;
    r = t[0];
    for (int k = 1; k < n; k++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          r[i][j] = W'(elem_ref(sel, int'(r[i][j]), int'(t[k][i][j])));
    return r;
  endfunction

  function automatic tile_t fill(int v);
    tile_t t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[i][j] = W'(v);
    return t;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_tile(input tile_t t, input logic last, input logic [3:0] o);
    int tmo = 0;
    in_tile = t; in_last = last; op = o; in_valid = 1'b1;
    while (!in_ready && tmo < 100) begin step(); tmo++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_group(input int sel, input tile_t t[4], input int n);
    for (int k = 0; k < n; k++) send_tile(t[k], k == n - 1, 4'(sel));
  endtask

  // Takes one tile off the output; meta_ok covers row order, out_last and timeouts.
  task automatic collect(output tile_t got, output bit meta_ok, output int stalls);
    meta_ok = 1'b1; stalls = 0; got = '0; out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int t = 0;
      while (!out_valid && t < 100) begin step(); t++; end
      stalls += t;
      if (!out_valid) meta_ok = 1'b0;
      if (out_row !== 2'(r) || out_last !== (r == 3)) meta_ok = 1'b0;
      got[r] = out_data;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_row, out_last, busy} !== 6'b100000 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy=%0b vld=%0b row=%0d last=%0b busy=%0b data=%h required 1 0 0 0 0 0",
               in_ready, out_valid, out_row, out_last, busy, out_data);
    end
  endtask

  task automatic test_single();
    tile_t t, got; bit ok; int st;
    t = '0; t[0][0] = 1; t[0][1] = 1; t[0][2] = 30; t[1][0] = 3;
    send_tile(t, 1'b1, 4'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_row !== 2'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: vld=%0b row=%0d busy=%0b required 1 0 1", out_valid, out_row, busy);
    end
    collect(got, ok, st);
    n_cmp++;
    if (got !== t) begin n_fail++; $display("FAIL single_data: got %h required %h", got, t); end
    n_cmp++;
    if (!ok || st != 0) begin n_fail++; $display("FAIL single_rows: meta=%0b stalls=%0d required 1 0", ok, st); end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: vld=%0b busy=%0b required 0 0", out_valid, busy);
    end
  endtask

  task automatic run_check(input string name, input int sel, input tile_t t[4], input int n, input tile_t exp);
    tile_t got; bit ok; int st;
    send_group(sel, t, n);
    collect(got, ok, st);
    n_cmp++;
    if (got !== exp || !ok) begin
      n_fail++; $display("FAIL %s: got %h meta=%0b required %h meta=1", name, got, ok, exp);
    end
  endtask

  task automatic test_ops();
    tile_t t[4];
    t[0] = fill(5); t[1] = fill(6); t[2] = fill(7); t[3] = '0;
    run_check("add3", 0, t, 3, fill(18));
    t[0] = fill(16'hFFFF); t[1] = fill(2);
    run_check("add_wrap", 0, t, 2, fill(1));
    t[0] = fill(7); t[1] = fill(3); t[2] = fill(9);
    run_check("min3", 2, t, 3, fill(3));
    run_check("max3", 1, t, 3, fill(9));
    t[0] = fill(16'h0101); t[1] = fill(16'h1010);
    run_check("or2", 3, t, 2, fill(16'h1111));
  endtask

  task automatic test_op_switch();
    tile_t got; bit ok; int st;
    send_tile(fill(5), 1'b0, 4'd0);
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midgroup_busy: busy=%0b vld=%0b required 1 0", busy, out_valid);
    end
    send_tile(fill(9), 1'b1, 4'd2);
    collect(got, ok, st);
    n_cmp++;
    if (got !== fill(14) || !ok) begin
      n_fail++; $display("FAIL op_switch: got %h required %h", got, fill(14));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    out_ready = 1'b0;
    send_tile(fill(4), 1'b1, 4'd0);
    send_tile(fill(8), 1'b1, 4'd0);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pending: rdy=%0b busy=%0b vld=%0b required 0 1 1", in_ready, busy, out_valid);
    end
    step(); step();
    n_cmp++;
    if (out_row !== 2'd0 || out_data !== fill(4)[0]) begin
      n_fail++; $display("FAIL hold: row=%0d data=%h required 0 %h", out_row, out_data, fill(4)[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp = (c < 4) ? W'(4) : W'(8);
      n_cmp++;
      if (out_valid !== 1'b1 || out_row !== 2'(c % 4) || out_data !== {4{exp}}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: vld=%0b row=%0d data=%h required 1 %0d %h",
                 c, out_valid, out_row, out_data, c % 4, {4{exp}});
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: rdy=%0b vld=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    tile_t got; bit ok; int st;
    send_tile(fill(1), 1'b1, 4'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_row !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: vld=%0b busy=%0b rdy=%0b row=%0d required 0 0 1 0", out_valid, busy, in_ready, out_row);
    end
    send_tile(fill(2), 1'b1, 4'd0);
    collect(got, ok, st);
    n_cmp++;
    if (got !== fill(2) || !ok) begin
      n_fail++; $display("FAIL after_reset: got %h meta=%0b required %h", got, ok, fill(2));
    end
  endtask

  task automatic test_random();
    tile_t t[4]; tile_t exp, got; bit ok; int st, n, sel, rng;
    for (int g = 0; g < 24; g++) begin
      n = $urandom_range(1, 4);
      sel = $urandom_range(0, 15);
      rng = ($urandom_range(0, 1) == 0) ? 15 : 65535;
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            t[k][i][j] = W'($urandom_range(0, rng));
      exp = group_ref(sel, t, n);
      for (int k = 0; k < n; k++)
        send_tile(t[k], k == n - 1, (k == 0) ? 4'(sel) : 4'($urandom_range(0, 15)));
      collect(got, ok, st);
      n_cmp++;
      if (got !== exp || !ok) begin
        n_fail++; $display("FAIL random_g%0d op=%0d n=%0d: got %h required %h", g, sel, n, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; op = '0; in_valid = 1'b0; in_last = 1'b0; in_tile = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_ops();
    test_op_switch();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
